// File: rtl/gcm_pkt_pkg.sv
// gcm_pkt_pkg: shared types and helpers for the GCM packet sequencer.
//   beat_e     - class of a beat issued to the cores (IDLE / HDR / BODY)
//   tag_ctl_t  - control part of the beat tag {valid, state, last}; the
//                lane-enable field is appended in the top, where LANES is known
//   beat_bytes - bytes consumed per beat across all lanes (BB)
//   payload_bytes - length field minus offset, clamped at zero
//   ceil_beats - number of BODY beats needed to carry a payload
package gcm_pkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2
    } beat_e;

    typedef struct packed {
        logic  valid;
        beat_e state;
        logic  last;
    } tag_ctl_t;

    function automatic int unsigned beat_bytes(input int unsigned lanes,
                                               input int unsigned data_w);
        return (lanes * data_w) / 32'd8;
    endfunction

    function automatic logic [15:0] payload_bytes(input logic [15:0] len,
                                                  input logic [15:0] offset);
        if (len > offset) begin
            return len - offset;
        end else begin
            return 16'd0;
        end
    endfunction

    function automatic logic [16:0] ceil_beats(input logic [15:0] payload,
                                               input logic [16:0] bb);
        return ({1'b0, payload} + bb - 17'd1) / bb;
    endfunction

endpackage

// File: rtl/gcm_tag_delay.sv
// gcm_tag_delay: fixed-depth shift register carrying a beat tag alongside
// the core pipeline. All stages clear on the asynchronous reset.
// Ports:
//   clk - clock
//   rst - asynchronous active-high clear
//   d   - tag entering the line (WIDTH bits)
//   q   - tag leaving the line, DEPTH cycles after it entered
module gcm_tag_delay #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // shift the tag one stage per cycle; reset empties the whole line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/gcm_pkt_sequencer.sv
// gcm_pkt_sequencer: classifies packet beats (header / body) for a bank of
// LANES gcm_aes cores, derives the GCM plaintext size from the length field,
// produces per-lane encrypt enables (partial final beats included) and delays
// the beat tag by CORE_LAT so it lines up with core ciphertext.
// Optional build macro: PKT_LEN_CHK_EN adds a body-beat counter and drives
// o_len_err; without it o_len_err is constant 0.
// Ports:
//   clk, reset       - clock, asynchronous active-high reset
//   i_valid          - beat present
//   i_new / i_last   - first / final beat of a packet (qualified by i_valid)
//   i_len            - packet length in bytes, sampled with i_new
//   o_core_valid/new/last, o_state, o_lane_en, o_pt_size - issue outputs,
//                      registered one cycle after the input beat
//   o_valid_dly, o_state_dly, o_last_dly, o_lane_en_dly - issue tag delayed
//                      by CORE_LAT cycles
//   o_len_err        - length / beat-count mismatch pulse
module gcm_pkt_sequencer
    import gcm_pkt_pkg::*;
#(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned LANES      = 2,
    parameter int unsigned HDR_WORDS  = 2,
    parameter int unsigned LEN_OFFSET = 14,
    parameter int unsigned CORE_LAT   = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic              i_new,
    input  logic              i_last,
    input  logic [15:0]       i_len,
    output logic              o_core_valid,
    output logic              o_core_new,
    output logic              o_core_last,
    output logic [63:0]       o_pt_size,
    output logic [LANES-1:0]  o_lane_en,
    output logic [1:0]        o_state,
    output logic              o_valid_dly,
    output logic [1:0]        o_state_dly,
    output logic              o_last_dly,
    output logic [LANES-1:0]  o_lane_en_dly,
    output logic              o_len_err
);

    localparam int unsigned BB         = beat_bytes(LANES, DATA_W);
    localparam int unsigned LANE_BYTES = DATA_W / 32'd8;
    localparam logic [15:0] BB16       = 16'(BB);
    localparam logic [15:0] OFF16      = 16'(LEN_OFFSET);
    localparam logic [3:0]  HDR_LAST   = 4'(HDR_WORDS);

    typedef struct packed {
        tag_ctl_t         ctl;
        logic [LANES-1:0] lane_en;
    } tag_t;

    localparam int unsigned TAG_W = $bits(tag_t);

    beat_e            state_r;
    beat_e            state_nxt_s;
    logic [3:0]       hdr_cnt_r;
    logic [3:0]       hdr_cnt_nxt_s;
    logic [15:0]      rem_r;
    logic [15:0]      rem_nxt_s;
    logic [63:0]      pt_size_r;
    logic [63:0]      pt_size_nxt_s;
    logic [15:0]      payload_s;
    logic             accept_s;
    logic             restart_s;
    beat_e            beat_cls_s;
    logic [LANES-1:0] lane_body_s;
    logic [LANES-1:0] lane_en_s;

    logic             core_valid_r;
    logic             core_new_r;
    logic             core_last_r;
    beat_e            state_out_r;
    logic [LANES-1:0] lane_en_r;

    tag_t             tag_in_s;
    tag_t             tag_dly_s;

    assign payload_s = payload_bytes(i_len, OFF16);

    // lane k still has data while more than k lane-widths of payload remain
    always_comb begin
        lane_body_s = {LANES{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            lane_body_s[k] = (32'(rem_r) > (32'(k) * LANE_BYTES));
        end
    end

    // next-state, beat classification and counter updates
    always_comb begin
        state_nxt_s   = state_r;
        hdr_cnt_nxt_s = hdr_cnt_r;
        rem_nxt_s     = rem_r;
        pt_size_nxt_s = pt_size_r;
        accept_s      = 1'b0;
        restart_s     = 1'b0;
        beat_cls_s    = ST_IDLE;
        lane_en_s     = {LANES{1'b0}};
        if (i_valid) begin
            if (i_new) begin
                // a new packet always starts as the first header beat,
                // even if one is already in flight
                accept_s      = 1'b1;
                restart_s     = (state_r != ST_IDLE);
                beat_cls_s    = ST_HDR;
                hdr_cnt_nxt_s = 4'd1;
                rem_nxt_s     = payload_s;
                pt_size_nxt_s = {45'd0, payload_s, 3'b000};
                if (i_last) begin
                    state_nxt_s = ST_IDLE;
                end else if (HDR_WORDS == 32'd1) begin
                    state_nxt_s = ST_BODY;
                end else begin
                    state_nxt_s = ST_HDR;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        // beat outside a packet: dropped
                        state_nxt_s = ST_IDLE;
                    end
                    ST_HDR: begin
                        accept_s      = 1'b1;
                        beat_cls_s    = ST_HDR;
                        hdr_cnt_nxt_s = hdr_cnt_r + 4'd1;
                        if (i_last) begin
                            state_nxt_s = ST_IDLE;
                        end else if ((hdr_cnt_r + 4'd1) == HDR_LAST) begin
                            state_nxt_s = ST_BODY;
                        end else begin
                            state_nxt_s = ST_HDR;
                        end
                    end
                    ST_BODY: begin
                        accept_s   = 1'b1;
                        beat_cls_s = ST_BODY;
                        lane_en_s  = lane_body_s;
                        if (rem_r > BB16) begin
                            rem_nxt_s = rem_r - BB16;
                        end else begin
                            rem_nxt_s = 16'd0;
                        end
                        if (i_last) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_BODY;
                        end
                    end
                    default: begin
                        state_nxt_s = ST_IDLE;
                    end
                endcase
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // packet counters, size latch and registered issue outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr_cnt_r    <= 4'd0;
            rem_r        <= 16'd0;
            pt_size_r    <= 64'd0;
            core_valid_r <= 1'b0;
            core_new_r   <= 1'b0;
            core_last_r  <= 1'b0;
            state_out_r  <= ST_IDLE;
            lane_en_r    <= {LANES{1'b0}};
        end else begin
            hdr_cnt_r    <= hdr_cnt_nxt_s;
            rem_r        <= rem_nxt_s;
            pt_size_r    <= pt_size_nxt_s;
            core_valid_r <= accept_s;
            core_new_r   <= accept_s & i_new;
            core_last_r  <= accept_s & i_last;
            state_out_r  <= beat_cls_s;
            lane_en_r    <= lane_en_s;
        end
    end

    // tag entering the delay line is the registered issue tag
    always_comb begin
        tag_in_s.ctl.valid = core_valid_r;
        tag_in_s.ctl.state = state_out_r;
        tag_in_s.ctl.last  = core_last_r;
        tag_in_s.lane_en   = lane_en_r;
    end

    gcm_tag_delay #(
        .WIDTH (TAG_W),
        .DEPTH (CORE_LAT)
    ) u_tag_delay (
        .clk (clk),
        .rst (reset),
        .d   (tag_in_s),
        .q   (tag_dly_s)
    );

    assign o_core_valid  = core_valid_r;
    assign o_core_new    = core_new_r;
    assign o_core_last   = core_last_r;
    assign o_pt_size     = pt_size_r;
    assign o_lane_en     = lane_en_r;
    assign o_state       = state_out_r;
    assign o_valid_dly   = tag_dly_s.ctl.valid;
    assign o_state_dly   = tag_dly_s.ctl.state;
    assign o_last_dly    = tag_dly_s.ctl.last;
    assign o_lane_en_dly = tag_dly_s.lane_en;

`ifdef PKT_LEN_CHK_EN
    localparam logic [16:0] BB17 = 17'(BB);

    logic [16:0] body_cnt_r;
    logic [16:0] body_cnt_nxt_s;
    logic [16:0] exp_beats_r;
    logic [16:0] exp_beats_nxt_s;
    logic [16:0] exp_new_s;
    logic        len_err_s;
    logic        len_err_r;

    // compare body beats seen against the count the length field implies;
    // a restart is always reported
    always_comb begin
        body_cnt_nxt_s  = body_cnt_r;
        exp_beats_nxt_s = exp_beats_r;
        len_err_s       = 1'b0;
        exp_new_s       = ceil_beats(payload_s, BB17);
        if (accept_s) begin
            if (i_new) begin
                body_cnt_nxt_s  = 17'd0;
                exp_beats_nxt_s = exp_new_s;
                len_err_s       = restart_s | (i_last & (exp_new_s != 17'd0));
            end else if (beat_cls_s == ST_BODY) begin
                body_cnt_nxt_s = body_cnt_r + 17'd1;
                len_err_s      = i_last & ((body_cnt_r + 17'd1) != exp_beats_r);
            end else begin
                len_err_s = i_last & (body_cnt_r != exp_beats_r);
            end
        end else begin
            len_err_s = 1'b0;
        end
    end

    // length-check state; the error pulse issues alongside o_core_last
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            body_cnt_r  <= 17'd0;
            exp_beats_r <= 17'd0;
            len_err_r   <= 1'b0;
        end else begin
            body_cnt_r  <= body_cnt_nxt_s;
            exp_beats_r <= exp_beats_nxt_s;
            len_err_r   <= len_err_s;
        end
    end

    assign o_len_err = len_err_r;
`else
    assign o_len_err = 1'b0;
`endif

endmodule

// File: tb/tb_gcm_pkt_sequencer.sv
module tb_gcm_pkt_sequencer;

    localparam int DATA_W     = 128;
    localparam int LANES      = 2;
    localparam int HDR_WORDS  = 2;
    localparam int LEN_OFFSET = 14;
    localparam int CORE_LAT   = 12;
    localparam int BB         = LANES * DATA_W / 8;
    localparam int LANE_B     = DATA_W / 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_valid;
    logic              i_new;
    logic              i_last;
    logic [15:0]       i_len;
    logic              o_core_valid;
    logic              o_core_new;
    logic              o_core_last;
    logic [63:0]       o_pt_size;
    logic [LANES-1:0]  o_lane_en;
    logic [1:0]        o_state;
    logic              o_valid_dly;
    logic [1:0]        o_state_dly;
    logic              o_last_dly;
    logic [LANES-1:0]  o_lane_en_dly;
    logic              o_len_err;

    gcm_pkt_sequencer #(
        .DATA_W     (DATA_W),
        .LANES      (LANES),
        .HDR_WORDS  (HDR_WORDS),
        .LEN_OFFSET (LEN_OFFSET),
        .CORE_LAT   (CORE_LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_valid       (i_valid),
        .i_new         (i_new),
        .i_last        (i_last),
        .i_len         (i_len),
        .o_core_valid  (o_core_valid),
        .o_core_new    (o_core_new),
        .o_core_last   (o_core_last),
        .o_pt_size     (o_pt_size),
        .o_lane_en     (o_lane_en),
        .o_state       (o_state),
        .o_valid_dly   (o_valid_dly),
        .o_state_dly   (o_state_dly),
        .o_last_dly    (o_last_dly),
        .o_lane_en_dly (o_lane_en_dly),
        .o_len_err     (o_len_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             v;
        logic             n;
        logic             l;
        logic [1:0]       st;
        logic [LANES-1:0] le;
        logic [63:0]      pt;
        logic             err;
    } exp_t;

    int vectors = 0;
    int miscompares = 0;

    // reference model: packet position as a plain beat index
    bit          m_active;
    int          m_idx;
    int          m_payload;
    logic [63:0] m_pt;
    exp_t        hist[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        assert (act === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    task automatic model_reset();
        m_active  = 1'b0;
        m_idx     = 0;
        m_payload = 0;
        m_pt      = 64'd0;
        hist.delete();
        for (int i = 0; i < CORE_LAT; i++) hist.push_back('0);
    endtask

    task automatic model_beat(input logic v, input logic n, input logic l,
                              input int len, output exp_t e);
        int rem;
`ifdef PKT_LEN_CHK_EN
        bit restart;
        int body_seen;
        restart = v && n && m_active;
`endif
        e = '0;
        if (v && n) begin
            m_active  = 1'b1;
            m_idx     = 0;
            m_payload = (len > LEN_OFFSET) ? len - LEN_OFFSET : 0;
            m_pt      = 64'(m_payload) * 64'd8;
        end
        e.pt = m_pt;
        if (v && m_active) begin
            e.v = 1'b1;
            e.n = n;
            e.l = l;
            if (m_idx < HDR_WORDS) begin
                e.st = 2'd1;
            end else begin
                e.st = 2'd2;
                rem = m_payload - (m_idx - HDR_WORDS) * BB;
                if (rem < 0) rem = 0;
                for (int k = 0; k < LANES; k++) e.le[k] = (rem > k * LANE_B);
            end
`ifdef PKT_LEN_CHK_EN
            body_seen = (m_idx + 1 > HDR_WORDS) ? m_idx + 1 - HDR_WORDS : 0;
            if (n) e.err = restart || (l && ceil_div(m_payload, BB) != 0);
            else if (l) e.err = (body_seen != ceil_div(m_payload, BB));
`endif
            m_idx++;
            if (l) m_active = 1'b0;
        end
    endtask

    task automatic check_all(input exp_t e, input exp_t d);
        chk("core_valid", 64'(o_core_valid), 64'(e.v));
        chk("core_new", 64'(o_core_new), 64'(e.n));
        chk("core_last", 64'(o_core_last), 64'(e.l));
        chk("state", 64'(o_state), 64'(e.st));
        chk("lane_en", 64'(o_lane_en), 64'(e.le));
        chk("pt_size", o_pt_size, e.pt);
        chk("len_err", 64'(o_len_err), 64'(e.err));
        chk("valid_dly", 64'(o_valid_dly), 64'(d.v));
        chk("state_dly", 64'(o_state_dly), 64'(d.st));
        chk("last_dly", 64'(o_last_dly), 64'(d.l));
        chk("lane_en_dly", 64'(o_lane_en_dly), 64'(d.le));
    endtask

    // one clock: drive a beat, step the model, check #1 after the edge
    task automatic cyc(input logic v, input logic n, input logic l, input int len);
        exp_t e;
        exp_t d;
        i_valid = v;
        i_new   = n;
        i_last  = l;
        i_len   = 16'(len);
        model_beat(v, n, l, len, e);
        @(posedge clk);
        #1;
        d = hist.pop_front();
        hist.push_back(e);
        check_all(e, d);
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        i_new   = 1'b0;
        i_last  = 1'b0;
        reset   = 1'b1;
        #1;
        model_reset();
        check_all('0, '0);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int nb;
        int len;
        reset   = 1'b1;
        i_valid = 1'b0;
        i_new   = 1'b0;
        i_last  = 1'b0;
        i_len   = 16'd0;
        model_reset();
        #1;
        check_all('0, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // len=78: 64 payload bytes, two full body beats
        cyc(1'b1, 1'b1, 1'b0, 78);
        chk("t1_pt", o_pt_size, 64'd512);
        cyc(1'b1, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b0, 0);
        chk("t1_le_b1", 64'(o_lane_en), 64'd3);
        cyc(1'b1, 1'b0, 1'b1, 0);
        chk("t1_last", 64'(o_core_last), 64'd1);

        // len=62: 48 payload bytes, final body beat uses lane 0 only
        cyc(1'b1, 1'b1, 1'b0, 62);
        chk("t2_pt", o_pt_size, 64'd384);
        cyc(1'b1, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b1, 0);
        chk("t2_le_partial", 64'(o_lane_en), 64'd1);

        // len below offset clamps to zero
        cyc(1'b1, 1'b1, 1'b0, 10);
        cyc(1'b1, 1'b0, 1'b1, 0);
        chk("t3_pt_clamp", o_pt_size, 64'd0);

        // beat outside a packet is dropped
        cyc(1'b1, 1'b0, 1'b0, 0);
        chk("stray_drop", 64'(o_core_valid), 64'd0);

        // boundary lengths
        cyc(1'b1, 1'b1, 1'b1, 14);
        cyc(1'b1, 1'b1, 1'b0, 15);
        chk("len15_pt", o_pt_size, 64'd8);
        cyc(1'b1, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b1, 0);
        cyc(1'b1, 1'b1, 1'b1, 65535);
        chk("len_max_pt", o_pt_size, 64'd524168);

        // restart without last
        cyc(1'b1, 1'b1, 1'b0, 100);
        cyc(1'b1, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b1, 1'b0, 30);
        chk("restart_state", 64'(o_state), 64'd1);
        chk("restart_pt", o_pt_size, 64'd128);
        cyc(1'b1, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b0, 0);

        // reset mid-BODY, then a non-new beat must be dropped
        do_reset();
        repeat (CORE_LAT) cyc(1'b0, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b0, 0);
        chk("post_reset_drop", 64'(o_core_valid), 64'd0);

        // random packets with gaps, restarts and stray beats
        repeat (400) begin
            nb  = int'($urandom_range(1, 8));
            len = int'($urandom_range(0, 320));
            for (int b = 0; b < nb; b++) begin
                while ($urandom_range(0, 3) == 0)
                    cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 65535)));
                cyc(1'b1, 1'(b == 0),
                    1'((b == nb - 1) && ($urandom_range(0, 9) != 0)),
                    (b == 0) ? len : int'($urandom_range(0, 65535)));
            end
            if ($urandom_range(0, 7) == 0) cyc(1'b1, 1'b0, 1'b0, 0);
        end
        repeat (CORE_LAT + 2) cyc(1'b0, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gcm_pkt_sequencer.md
Name: gcm_pkt_sequencer

Overview:
Parametrised packet-word sequencer that drives a bank of LANES gcm_aes cores. It tracks each packet's beat position (header vs body) and derives the GCM plaintext size from the packet length field. It generates per-lane encrypt enables, including partial final beats. It carries the beat tag (state/last/lane enables) through a fixed-latency delay line so the output phase logic sees the tag aligned with core ciphertext. It replaces the fixed two-header-word, two-core sequencing with configurable header depth, lane count and core latency.

Parameters:
DATA_W, 128, bits per lane per beat (one AES block)
LANES, 2, gcm_aes cores fed per beat
HDR_WORDS, 2, beats per packet forwarded in clear before payload (1..15)
LEN_OFFSET, 14, bytes subtracted from length field to obtain payload bytes
CORE_LAT, 12, gcm_aes input-to-ciphertext latency in cycles (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
i_valid  in  1  beat present this cycle
i_new  in  1  first beat of a packet (qualified by i_valid)
i_last  in  1  final beat of a packet (qualified by i_valid)
i_len  in  16  packet length in bytes, sampled on i_valid&&i_new
o_core_valid  out  1  beat issued to cores
o_core_new  out  1  i_new_instance to cores
o_core_last  out  1  i_last_instance to cores
o_pt_size  out  64  plaintext size in bits for current packet
o_lane_en  out  LANES  per-lane encrypt enable, lane 0 = lowest bytes
o_state  out  2  beat class issued: 0 IDLE, 1 HDR, 2 BODY
o_valid_dly  out  1  o_core_valid delayed CORE_LAT
o_state_dly  out  2  o_state delayed CORE_LAT
o_last_dly  out  1  o_core_last delayed CORE_LAT
o_lane_en_dly  out  LANES  o_lane_en delayed CORE_LAT
o_len_err  out  1  length/beat-count mismatch pulse (optional feature)

Behaviour:
- Reset (async): FSM IDLE, counters 0, every output 0, delay line cleared. Reset mid-packet abandons the packet; subsequent beats without i_new are ignored.
- FSM, advancing only on i_valid:
  - IDLE: on i_new -> HDR (hdr_cnt=1), or BODY if HDR_WORDS==1. i_valid without i_new is dropped (o_core_valid stays 0).
  - HDR: hdr_cnt++; when hdr_cnt reaches HDR_WORDS -> BODY.
  - BODY: stays until i_last.
  - i_last in any state -> IDLE after that beat. i_new&&i_last is a single-beat packet.
  - i_new in HDR/BODY restarts a packet: counters reload, beat treated as the first header beat.
- Size: payload = (i_len > LEN_OFFSET) ? i_len-LEN_OFFSET : 0. Clamp, never wrap. pt_size = payload<<3, zero-extended to 64 bits, latched on i_new and held until next i_new.
- Remaining bytes: rem loads payload on i_new and decrements by BB = LANES*DATA_W/8 per BODY beat, saturating at 0.
- Lane enables: HDR and IDLE beats give all zeros. BODY beat: o_lane_en[k] = (rem > k*DATA_W/8), using rem before decrement.
- Issue timing: o_core_* / o_state / o_lane_en are registered, one cycle after the input beat. They are 0 on cycles with no accepted beat.
- Delay line: {valid, state, last, lane_en} shifted CORE_LAT stages and cleared on reset. The *_dly outputs equal the issue outputs exactly CORE_LAT cycles later. There is no backpressure; one beat per cycle is sustained.

Optional Feature:
PKT_LEN_CHK_EN:
- Defined: count BODY beats per packet. On the last beat, compare against ceil(payload/BB). o_len_err pulses for 1 cycle, aligned with o_core_last, on mismatch. A restart (i_new in HDR/BODY) also pulses o_len_err aligned with that beat.
- Undefined: o_len_err tied 0 and the body counter is not built.

Decomposition:
- Shared package gcm_pkt_pkg: beat-class enum (IDLE/HDR/BODY), tag struct {valid, state, last, lane_en}, BB constant function.
- One sub-module, gcm_tag_delay: parametrised width/depth shift register with async clear, used for the *_dly path.

Test Plan:
- Defaults, len=78, beats new,h,b,b+last -> pt_size=512, lane_en 00,00,11,11, state 1,1,2,2, o_core_last on 4th issue.
- len=62, 2 header + 2 body beats -> pt_size=384, body lane_en 11 then 01.
- len=10, new,h+last -> pt_size=0, lane_en all 00, no wrap to a large size.
- CORE_LAT=12, random valid gaps -> *_dly equals issue outputs exactly 12 cycles later, every cycle.
- new,h,b then new again without last -> second packet restarts in HDR, pt_size reloaded. With PKT_LEN_CHK_EN, o_len_err=1 on the restart beat.
- reset asserted mid-BODY for 1 cycle -> all outputs 0 immediately, delay outputs 0 for 12 cycles, next non-new beat dropped.
